// File: rtl/core_pipeline_pkg.sv
// rtl/core_pipeline_pkg.sv - shared pipeline types and constants
// Purpose: types shared between the fetch queue and its storage.
//   fetch_entry_t : one fetched {pc, inst} pair (64 bits, pc in the upper half)
//   INST_NOP      : addi x0,x0,0, used as the decode-side bubble
package core_pipeline_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] INST_NOP = 32'h00000013;

endpackage

// File: rtl/fetch_queue_storage.sv
// rtl/fetch_queue_storage.sv - DEPTH x 64 register array for the fetch queue
// Purpose: entry storage with one synchronous write port and one
// asynchronous read port. Contents are not reset.
// Ports:
//   clock : write clock
//   we    : write enable
//   waddr : write index
//   wdata : entry to write
//   raddr : read index
//   rdata : entry at raddr (combinational)
module fetch_queue_storage
  import core_pipeline_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fetch_entry_t  wdata,
  input  logic [AW-1:0] raddr,
  output fetch_entry_t  rdata
);

  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_inst_queue.sv
// rtl/fetch_inst_queue.sv - fetch-to-decode instruction queue
// Purpose: circular buffer decoupling instruction fetch from decode, with a
// NOP bubble when empty and a one-cycle flush for control-flow redirects.
// Ports:
//   clock, reset      : core clock; asynchronous active-low reset
//   flush             : discard all entries this cycle
//   enq_valid/enq_ready, enq_pc, enq_inst : fetch-side handshake and payload
//   id_valid/id_ready, id_pc, id_inst     : decode-side handshake and payload
//   occupancy         : registered entry count
module fetch_inst_queue
  import core_pipeline_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = INST_NOP
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     enq_valid,
  input  logic [31:0]              enq_pc,
  input  logic [31:0]              enq_inst,
  output logic                     enq_ready,
  output logic                     id_valid,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_inst,
  input  logic                     id_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic         enq_fire;
  logic         deq_fire;
  fetch_entry_t wr_entry;
  fetch_entry_t rd_entry;

  // enq_ready is built only from registered count and flush, keeping
  // id_ready out of the upstream ready path.
  assign enq_ready = (count_q != FULL) && !flush;
  assign id_valid  = (count_q != '0);
  assign enq_fire  = enq_valid && enq_ready;
  // A flush overrides any consume in the same cycle.
  assign deq_fire  = id_valid && id_ready && !flush;

  assign wr_entry  = '{pc: enq_pc, inst: enq_inst};

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + AW'(1);
      if (deq_fire) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_queue_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clock (clock),
    .we    (enq_fire),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  // Storage is not reset, so the head is masked to a bubble when empty.
  assign id_pc     = id_valid ? rd_entry.pc   : 32'h0;
  assign id_inst   = id_valid ? rd_entry.inst : NOP_INST;
  assign occupancy = count_q;

`ifndef SYNTHESIS
  a_count_range: assert property (@(posedge clock) disable iff (!reset)
    count_q <= FULL);
  a_no_enq_full: assert property (@(posedge clock) disable iff (!reset)
    !(enq_fire && count_q == FULL));
  a_no_deq_empty: assert property (@(posedge clock) disable iff (!reset)
    !(deq_fire && count_q == '0));
  a_pc_aligned: assert property (@(posedge clock) disable iff (!reset)
    enq_fire |-> (enq_pc[1:0] == 2'b00));
`endif

endmodule

// File: tb/tb_fetch_inst_queue.sv
// tb/tb_fetch_inst_queue.sv - self-checking bench for fetch_inst_queue
module tb_fetch_inst_queue;

  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        enq_valid;
  logic [31:0] enq_pc;
  logic [31:0] enq_inst;
  logic        enq_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;
  logic [$clog2(DEPTH):0] occupancy;

  int checks   = 0;
  int failures = 0;

  fetch_inst_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_pc    (enq_pc),
    .enq_inst  (enq_inst),
    .enq_ready (enq_ready),
    .id_valid  (id_valid),
    .id_pc     (id_pc),
    .id_inst   (id_inst),
    .id_ready  (id_ready),
    .occupancy (occupancy)
  );

  always #5 clock = ~clock;

  // Reference model: an ordered list of {pc, inst} pairs.
  logic [63:0] mq[$];

  always @(posedge clock or negedge reset) begin
    if (!reset || flush) begin
      mq.delete();
    end else begin
      int  sz;
      bit  do_deq;
      bit  do_enq;
      sz     = mq.size();
      do_deq = (sz > 0) && id_ready;
      do_enq = enq_valid && (sz < DEPTH);
      if (do_deq) void'(mq.pop_front());
      if (do_enq) mq.push_back({enq_pc, enq_inst});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    logic [31:0] e_pc, e_inst;
    int sz;
    sz     = mq.size();
    e_pc   = (sz > 0) ? mq[0][63:32] : 32'h0;
    e_inst = (sz > 0) ? mq[0][31:0]  : NOP;
    chk("m_id_valid",  {31'b0, id_valid},  {31'b0, sz > 0});
    chk("m_id_pc",     id_pc,   e_pc);
    chk("m_id_inst",   id_inst, e_inst);
    chk("m_occupancy", 32'(occupancy), 32'(sz));
    chk("m_enq_ready", {31'b0, enq_ready}, {31'b0, (sz != DEPTH) && !flush});
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ev, input logic [31:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic fl);
    enq_valid = ev;
    enq_pc    = pc;
    enq_inst  = inst;
    id_ready  = rdy;
    flush     = fl;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);

    // Reset then idle
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("rst_id_valid",  {31'b0, id_valid}, 32'h0);
    chk("rst_id_inst",   id_inst, 32'h00000013);
    chk("rst_occupancy", 32'(occupancy), 32'h0);
    chk("rst_enq_ready", {31'b0, enq_ready}, 32'h1);

    // Single pass-through
    step();
    drive(1, 32'h100, 32'h00500093, 1, 0);
    step();
    drive(0, 0, 0, 1, 0);
    @(negedge clock);
    chk("pt_id_valid", {31'b0, id_valid}, 32'h1);
    chk("pt_id_pc",    id_pc, 32'h100);
    chk("pt_id_inst",  id_inst, 32'h00500093);
    step();
    @(negedge clock);
    chk("pt_empty", {31'b0, id_valid}, 32'h0);

    // Fill and stall
    step();
    drive(1, 32'h0, 32'hA0000013, 0, 0);
    step();
    drive(1, 32'h4, 32'hA4000013, 0, 0);
    step();
    drive(1, 32'h8, 32'hA8000013, 0, 0);
    @(negedge clock);
    chk("fs_occ_full",   32'(occupancy), 32'h2);
    chk("fs_enq_ready",  {31'b0, enq_ready}, 32'h0);
    chk("fs_head",       id_pc, 32'h0);
    step();
    id_ready = 1'b1;
    @(negedge clock);
    chk("fs_drain0_occ", 32'(occupancy), 32'h2);
    chk("fs_drain0_pc",  id_pc, 32'h0);
    step();
    @(negedge clock);
    chk("fs_drain1_pc",  id_pc, 32'h4);
    step();
    enq_valid = 1'b0;
    @(negedge clock);
    chk("fs_drain2_pc",  id_pc, 32'h8);
    chk("fs_drain2_occ", 32'(occupancy), 32'h1);
    step();
    @(negedge clock);
    chk("fs_drained", {31'b0, id_valid}, 32'h0);

    // Simultaneous enq/deq with pointer wrap
    step();
    drive(1, 32'h0, 32'h00000093, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      if (i < 9) drive(1, 32'((i + 1) * 4), 32'(32'h100 + i + 1), 1, 0);
      else       drive(0, 0, 0, 1, 0);
      @(negedge clock);
      chk("wrap_pc",  id_pc, 32'(i * 4));
      chk("wrap_occ", 32'(occupancy), 32'h1);
    end
    step();
    @(negedge clock);
    chk("wrap_empty", {31'b0, id_valid}, 32'h0);

    // Flush with traffic
    step();
    drive(1, 32'h300, 32'h11, 0, 0);
    step();
    drive(1, 32'h304, 32'h22, 0, 0);
    step();
    drive(1, 32'h308, 32'h33, 1, 1);
    @(negedge clock);
    chk("fl_pre_occ",   32'(occupancy), 32'h2);
    chk("fl_pre_pc",    id_pc, 32'h300);
    chk("fl_enq_ready", {31'b0, enq_ready}, 32'h0);
    step();
    drive(0, 0, 0, 0, 0);
    @(negedge clock);
    chk("fl_occ",   32'(occupancy), 32'h0);
    chk("fl_valid", {31'b0, id_valid}, 32'h0);
    step();
    @(negedge clock);
    chk("fl_no_ghost", {31'b0, id_valid}, 32'h0);

    // Asynchronous reset mid-operation
    step();
    drive(1, 32'h400, 32'h44, 0, 0);
    step();
    drive(1, 32'h404, 32'h55, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    @(negedge clock);
    chk("ar_pre_occ", 32'(occupancy), 32'h2);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", {31'b0, id_valid}, 32'h0);
    chk("ar_occ",   32'(occupancy), 32'h0);
    chk("ar_inst",  id_inst, NOP);
    step();
    reset = 1'b1;
    drive(1, 32'h200, 32'h66, 1, 0);
    step();
    drive(0, 0, 0, 1, 0);
    @(negedge clock);
    chk("ar_first_pc", id_pc, 32'h200);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step();
      drive($urandom_range(0, 9) < 7, $urandom & 32'hFFFF_FFFC, $urandom,
            $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    end
    step();
    drive(0, 0, 0, 0, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_inst_queue.md
Name: fetch_inst_queue

Overview:
- Decoupling queue between the text memory interface (instruction fetch side) and the decode stage.
- Captures each fetched {pc, inst} pair when the fetch side presents it with a valid/ready handshake.
- Presents pairs in order to decode with a valid/ready handshake; supplies a NOP bubble when empty.
- Flush on control-flow redirect discards all queued (wrong-path) instructions in one cycle.

Parameters:
- DEPTH, 2, number of entries; power of two, ≥2.
- NOP_INST, 32'h00000013, instruction word driven on id_inst when id_valid=0 (addi x0,x0,0).

Ports:
- clock  input  1  core clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset: asserted when 0, deasserted synchronously to clock by the top level.
- flush  input  1  synchronous discard of all entries (branch/jump/trap redirect).
- enq_valid  input  1  fetch side has an instruction (driven from inst_available qualified by fetch control).
- enq_pc  input  32  PC of enq_inst.
- enq_inst  input  32  instruction word.
- enq_ready  output  1  queue can accept this cycle.
- id_valid  output  1  head entry valid toward decode.
- id_pc  output  32  head entry PC.
- id_inst  output  32  head entry instruction, NOP_INST when empty.
- id_ready  input  1  decode consumes head this cycle.
- occupancy  output  $clog2(DEPTH)+1  current entry count.

Behaviour:
- Storage: circular buffer of DEPTH entries {pc, inst}; rd_ptr, wr_ptr $clog2(DEPTH) bits, wrap modulo DEPTH; count $clog2(DEPTH)+1 bits, range 0..DEPTH.
- enq fires when enq_valid && enq_ready; deq fires when id_valid && id_ready.
- enq_ready = (count != DEPTH) && !flush. It depends only on registered state and flush, never on id_ready, so there is no combinational path from id_ready to enq_ready.
- id_valid = (count != 0). id_pc and id_inst come from the entry at rd_ptr. When empty: id_pc = 0, id_inst = NOP_INST.
- No empty-queue bypass: an enqueued entry appears on id_* the cycle after enq fires (latency 1).
- Enq and deq in the same cycle:
  - count unchanged; both pointers advance.
  - Legal for any count with 1 ≤ count ≤ DEPTH−1.
  - At count == DEPTH, enq is blocked by enq_ready=0, so a deq alone lowers count to DEPTH−1.
- Enq only: the entry is written at wr_ptr, wr_ptr+1, count+1.
- Deq only: rd_ptr+1, count−1.
- Full (count == DEPTH): enq_ready=0. enq_valid may stay high; the entry is neither stored nor lost. Upstream holds it until enq_ready=1.
- Empty (count == 0): id_valid=0. id_ready is ignored; no pointer or count change.
- flush=1 (highest priority over enq/deq that cycle):
  - Next cycle: count=0, rd_ptr=wr_ptr=0, id_valid=0.
  - Any enq_valid or id_ready in the flush cycle has no effect.
  - id_* outputs during the flush cycle still reflect pre-flush state. Decode must ignore them, since it is flushed by the same signal.
- Reset (reset==0, asynchronous, at any time including mid-transfer):
  - count=0, rd_ptr=0, wr_ptr=0.
  - Outputs: id_valid=0, id_pc=0, id_inst=NOP_INST, occupancy=0, enq_ready=1 once reset==1 and flush==0.
  - Storage array contents are don't-care and not reset.
- occupancy = count, registered.
- Assertions (simulation only):
  - count never exceeds DEPTH.
  - No enq fire while count==DEPTH.
  - No deq fire while count==0.
  - enq_pc is word-aligned (enq_pc[1:0]==0) on every enq fire.

Decomposition:
- Shared package core_pipeline_pkg holds:
  - typedef fetch_entry_t: struct packed {logic [31:0] pc; logic [31:0] inst;}.
  - Constant INST_NOP = 32'h00000013, used as the NOP_INST default.
- One natural sub-module, fetch_queue_storage: DEPTH×64 register array, with one write port (we, waddr, wdata) and one asynchronous read port (raddr → rdata).
- Pointers, count, handshake and flush logic stay in fetch_inst_queue.
- Expected size: ~150–220 lines total.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release. Required: id_valid=0, id_inst=32'h00000013, occupancy=0, enq_ready=1.
- Single pass-through: enq {pc=0x100, inst=0x00500093} with id_ready=1. Next cycle id_valid=1, id_pc=0x100, id_inst=0x00500093. Following cycle id_valid=0.
- Fill and stall: DEPTH=2, id_ready=0, enqueue pcs 0x0, 0x4, 0x8 back-to-back. Required: 0x0 and 0x4 accepted, enq_ready=0 with occupancy=2 while 0x8 is held. Then id_ready=1 drains 0x0, 0x4, 0x8 in order with no duplicate or loss.
- Simultaneous enq/deq at occupancy=1: occupancy stays 1 and output order is preserved. Pointer wrap across 10 consecutive transfers yields pcs 0x0..0x24 in order.
- Flush with traffic: occupancy=2, assert flush with enq_valid=1 and id_ready=1 the same cycle. Next cycle occupancy=0, id_valid=0, and the flush-cycle enq entry never appears.
- Async reset mid-operation: occupancy=2, drive reset=0 between clock edges. Required: id_valid=0 and occupancy=0 immediately, without waiting for a clock edge. After release, the first enqueued pc=0x200 is the first dequeued.
